// File: rtl/rst_seq_pkg.sv
// Shared definitions for the reset sequencer: FSM state encodings and the
// counter sizing helper.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_WAIT_LOCK = 2'd0,
        ST_HOLD      = 2'd1,
        ST_RELEASE   = 2'd2,
        ST_RUN       = 2'd3
    } seq_state_t;

    // One spare bit above the largest terminal count, so the counter can never wrap.
    function automatic int cnt_width(input int lock_filter, input int hold_cycles,
                                     input int stagger_cycles);
        int m;
        m = lock_filter;
        if (hold_cycles > m) m = hold_cycles;
        if (stagger_cycles > m) m = stagger_cycles;
        return $clog2(m) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for bringing asynchronous levels into the local clock
// domain. Synchronous active-high reset clears both stages.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Power-on / lock-loss reset sequencer: qualifies a synchronised PLL lock,
// holds every domain in reset, then releases the domains one by one.
module reset_sequencer
    import rst_seq_pkg::*;
#(
    parameter int NUM_OUT        = 2,
    parameter int LOCK_FILTER    = 4,
    parameter int HOLD_CYCLES    = 16,
    parameter int STAGGER_CYCLES = 4
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_locked,
    input  logic               i_sw_reset,
    output logic [NUM_OUT-1:0] o_reset,
    output logic               o_ready,
    output logic [1:0]         o_state
);

    localparam int CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, STAGGER_CYCLES);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_FILTER - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] STAG_LAST = CW'(STAGGER_CYCLES - 1);
    localparam logic [NUM_OUT-1:0] ALL_ON = {NUM_OUT{1'b1}};

    seq_state_t         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [NUM_OUT-1:0] rst_q, rst_d;
    logic               ready_q, ready_d;
    logic [NUM_OUT-1:0] rst_shift;
    logic               lk_s;

    sync_2ff #(
        .WIDTH(1)
    ) u_lock_sync (
        .clk(i_clock),
        .rst(i_reset),
        .d  (i_locked),
        .q  (lk_s)
    );

    // Shifting left clears the lowest still-asserted bit, so domains release in ascending order.
    assign rst_shift = rst_q << 1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= ALL_ON;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            ready_q <= ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        ready_d = ready_q;
        if (!lk_s) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
            rst_d   = ALL_ON;
            ready_d = 1'b0;
        end else if (i_sw_reset && (state_q != ST_WAIT_LOCK)) begin
            state_d = ST_HOLD;
            cnt_d   = '0;
            rst_d   = ALL_ON;
            ready_d = 1'b0;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    if (cnt_q == LOCK_LAST) begin
                        state_d = ST_HOLD;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        cnt_d = '0;
                        rst_d = rst_shift;
                        if (rst_shift == '0) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    if (cnt_q == STAG_LAST) begin
                        cnt_d = '0;
                        rst_d = rst_shift;
                        if (rst_shift == '0) begin
                            state_d = ST_RUN;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_d = '0;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                    rst_d   = ALL_ON;
                    ready_d = 1'b0;
                end
            endcase
        end
    end

    // o_ready is a level, not a handshake: high exactly while every o_reset bit is low.
    assign o_reset = rst_q;
    assign o_ready = ready_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: a two-output and a one-output instance share the
// stimulus and are scored every edge against a timestamp-based model.
module tb_reset_sequencer;

    localparam int LOCK_FILTER    = 4;
    localparam int HOLD_CYCLES    = 16;
    localparam int STAGGER_CYCLES = 4;

    logic       clk = 1'b0;
    logic       i_reset;
    logic       i_locked;
    logic       i_sw_reset;
    logic [1:0] rst_a;
    logic       ready_a;
    logic [1:0] state_a;
    logic [0:0] rst_b;
    logic       ready_b;
    logic [1:0] state_b;

    always #5 clk = ~clk;

    reset_sequencer #(
        .NUM_OUT(2), .LOCK_FILTER(LOCK_FILTER),
        .HOLD_CYCLES(HOLD_CYCLES), .STAGGER_CYCLES(STAGGER_CYCLES)
    ) dut_a (
        .i_clock(clk), .i_reset(i_reset), .i_locked(i_locked),
        .i_sw_reset(i_sw_reset), .o_reset(rst_a), .o_ready(ready_a), .o_state(state_a)
    );

    reset_sequencer #(
        .NUM_OUT(1), .LOCK_FILTER(LOCK_FILTER),
        .HOLD_CYCLES(HOLD_CYCLES), .STAGGER_CYCLES(STAGGER_CYCLES)
    ) dut_b (
        .i_clock(clk), .i_reset(i_reset), .i_locked(i_locked),
        .i_sw_reset(i_sw_reset), .o_reset(rst_b), .o_ready(ready_b), .o_state(state_b)
    );

    // phase: 0 wait-lock, 1 hold, 2 release, 3 run; times are edge numbers.
    typedef struct {
        int phase;
        int lock_run;
        int t_hold;
        int t_rel;
        int released;
        bit d1;
        bit d2;
    } model_t;

    model_t     ma, mb;
    int         edge_no;
    int         mon_edge;
    int         n_checks;
    int         n_errors;
    logic [4:0] exp_q_a[$];
    logic [4:0] exp_q_b[$];

    function automatic model_t model_step(model_t m, int n, int e, bit r, bit l, bit s);
        bit lk;
        lk = m.d2;
        if (r) begin
            m.phase = 0; m.lock_run = 0; m.released = 0; m.d1 = 1'b0; m.d2 = 1'b0;
            return m;
        end
        m.d2 = m.d1;
        m.d1 = l;
        if (!lk) begin
            m.phase = 0; m.lock_run = 0; m.released = 0;
        end else if (s && m.phase != 0) begin
            m.phase = 1; m.t_hold = e; m.released = 0;
        end else begin
            case (m.phase)
                0: begin
                    m.lock_run++;
                    if (m.lock_run == LOCK_FILTER) begin
                        m.phase = 1; m.t_hold = e; m.lock_run = 0;
                    end
                end
                1: if (e - m.t_hold == HOLD_CYCLES) begin
                    m.released = 1; m.t_rel = e;
                    m.phase = (n == 1) ? 3 : 2;
                end
                2: if ((e - m.t_rel) % STAGGER_CYCLES == 0) begin
                    m.released = 1 + (e - m.t_rel) / STAGGER_CYCLES;
                    if (m.released == n) m.phase = 3;
                end
                default: ;
            endcase
        end
        return m;
    endfunction

    function automatic logic [4:0] model_out(model_t m, int n);
        int         rb;
        logic [1:0] ph;
        ph = m.phase[1:0];
        rb = ((1 << n) - 1) & ~((1 << m.released) - 1);
        return {ph, (m.phase == 3), rb[1:0]};
    endfunction

    task automatic drive(input bit r, input bit l, input bit s);
        i_reset    = r;
        i_locked   = l;
        i_sw_reset = s;
        edge_no++;
        ma = model_step(ma, 2, edge_no, r, l, s);
        mb = model_step(mb, 1, edge_no, r, l, s);
        @(posedge clk);
        exp_q_a.push_back(model_out(ma, 2));
        exp_q_b.push_back(model_out(mb, 1));
        #1;
    endtask

    task automatic check_val(input string name, input logic [2:0] got, input logic [2:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, got, want);
        end
    endtask

    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q_a.size() > 0) begin
            mon_edge++;
            e = exp_q_a.pop_front();
            n_checks++;
            if ({state_a, ready_a, rst_a} !== e) begin
                n_errors++;
                $display("FAIL seq_a edge %0d: got state/ready/reset %b expected %b",
                         mon_edge, {state_a, ready_a, rst_a}, e);
            end
        end
        if (exp_q_b.size() > 0) begin
            e = exp_q_b.pop_front();
            n_checks++;
            if ({state_b, ready_b, 1'b0, rst_b} !== e) begin
                n_errors++;
                $display("FAIL seq_b edge %0d: got state/ready/reset %b expected %b",
                         mon_edge, {state_b, ready_b, 1'b0, rst_b}, e);
            end
        end
    end

    initial begin
        bit lk;
        n_checks = 0; n_errors = 0; edge_no = 0; mon_edge = 0;
        ma = '{default: 0}; mb = '{default: 0};
        drive(1, 0, 0);
        drive(1, 0, 0);

        // Power-up timeline with explicit edge checks.
        for (int n = 1; n <= 30; n++) begin
            drive(0, 1, 0);
            if (n == 21) check_val("a_edge21", {ready_a, rst_a}, 3'b011);
            if (n == 22) check_val("a_edge22", {ready_a, rst_a}, 3'b010);
            if (n == 25) check_val("a_edge25", {ready_a, rst_a}, 3'b010);
            if (n == 26) check_val("a_edge26", {ready_a, rst_a}, 3'b100);
            if (n == 21) check_val("b_edge21", {1'b0, ready_b, rst_b}, 3'b001);
            if (n == 22) check_val("b_edge22", {1'b0, ready_b, rst_b}, 3'b010);
        end

        // Software reset pulse from run.
        drive(0, 1, 1);
        for (int n = 0; n < 25; n++) drive(0, 1, 0);

        // Lock loss in run, then re-lock.
        for (int n = 0; n < 5; n++) drive(0, 0, 0);
        for (int n = 0; n < 30; n++) drive(0, 1, 0);

        // Lock glitch during qualification after a reset.
        drive(1, 0, 0);
        for (int n = 0; n < 3; n++) drive(0, 1, 0);
        drive(0, 0, 0);
        for (int n = 0; n < 30; n++) drive(0, 1, 0);

        // Software reset coinciding with lock loss.
        for (int n = 0; n < 4; n++) drive(0, 0, 1);
        for (int n = 0; n < 30; n++) drive(0, 1, 0);

        // Reset mid-hold discards progress.
        for (int n = 0; n < 10; n++) drive(0, 1, 0);
        drive(1, 1, 0);
        for (int n = 0; n < 30; n++) drive(0, 1, 0);

        lk = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            if (lk) lk = ($urandom_range(0, 79) != 0);
            else    lk = ($urandom_range(0, 3) == 0);
            drive(($urandom_range(0, 399) == 0), lk, ($urandom_range(0, 24) == 0));
        end

        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (exp_q_a.size() != 0 || exp_q_b.size() != 0) begin
            n_errors++;
            $display("FAIL queue_drain: got %0d/%0d pending expected 0",
                     exp_q_a.size(), exp_q_b.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
